// File: rtl/e203_icb_arb2.sv
// e203_icb_arb2: two-master ICB arbiter onto one ICB target port.
// The arbiter picks one pending command per cycle and forwards it
// combinationally. It records the grant order in an outstanding-ID FIFO,
// so in-order target responses are routed back to the master that issued them.
// Build option: define E203_ICB_ARB_RR_EN for round-robin arbitration.
// Without it, arbitration is fixed priority with m0 over m1.
//
// Handshake rule for every channel: a transfer happens on a rising clk edge
// where valid and ready are both 1. A valid command or response holds its
// payload stable until that transfer. ready may depend combinationally on
// valid, but the arbiter never lets a valid depend on the matching ready.
module e203_icb_arb2 #(
   parameter int AW         = 32,
   parameter int OUTS_DEPTH = 2
) (
   input  logic          clk,
   input  logic          rst,

   input  logic          m0_icb_cmd_valid,
   output logic          m0_icb_cmd_ready,
   input  logic [AW-1:0] m0_icb_cmd_addr,
   input  logic          m0_icb_cmd_read,
   input  logic [31:0]   m0_icb_cmd_wdata,
   input  logic [3:0]    m0_icb_cmd_wmask,
   output logic          m0_icb_rsp_valid,
   input  logic          m0_icb_rsp_ready,
   output logic          m0_icb_rsp_err,
   output logic [31:0]   m0_icb_rsp_rdata,

   input  logic          m1_icb_cmd_valid,
   output logic          m1_icb_cmd_ready,
   input  logic [AW-1:0] m1_icb_cmd_addr,
   input  logic          m1_icb_cmd_read,
   input  logic [31:0]   m1_icb_cmd_wdata,
   input  logic [3:0]    m1_icb_cmd_wmask,
   output logic          m1_icb_rsp_valid,
   input  logic          m1_icb_rsp_ready,
   output logic          m1_icb_rsp_err,
   output logic [31:0]   m1_icb_rsp_rdata,

   output logic          t_icb_cmd_valid,
   input  logic          t_icb_cmd_ready,
   output logic [AW-1:0] t_icb_cmd_addr,
   output logic          t_icb_cmd_read,
   output logic [31:0]   t_icb_cmd_wdata,
   output logic [3:0]    t_icb_cmd_wmask,
   input  logic          t_icb_rsp_valid,
   output logic          t_icb_rsp_ready,
   input  logic          t_icb_rsp_err,
   input  logic [31:0]   t_icb_rsp_rdata,

   output logic          busy
);

   // Pointers carry one extra wrap bit beyond the index so full and empty
   // can be told apart. They wrap naturally modulo 2*OUTS_DEPTH.
   localparam int           PW       = $clog2(OUTS_DEPTH) + 1;
   localparam logic [PW-1:0] IDX_MASK = PW'(OUTS_DEPTH - 1);
   localparam logic [PW-1:0] FULL_XOR = PW'(OUTS_DEPTH);

   logic                  sel;
   logic                  sel_valid;
   logic                  lock;
   logic                  lock_id;
   logic                  cmd_hs;
   logic                  rsp_hs;
   logic                  full;
   logic                  empty;
   logic                  head;
   logic [PW-1:0]         wptr;
   logic [PW-1:0]         rptr;
   logic [PW-1:0]         wr_idx;
   logic [PW-1:0]         rd_idx;
   logic [OUTS_DEPTH-1:0] id_mem;

`ifdef E203_ICB_ARB_RR_EN
   logic                  last_gnt;
`endif

   // Grant selection. It uses only registered state and the master valids,
   // so there is no path from t_icb_cmd_ready into sel.
   always_comb begin
      sel = 1'b0;
      if (lock) begin
         sel = lock_id;
      end else if (m0_icb_cmd_valid && m1_icb_cmd_valid) begin
`ifdef E203_ICB_ARB_RR_EN
         sel = ~last_gnt;
`else
         sel = 1'b0;
`endif
      end else if (m1_icb_cmd_valid) begin
         sel = 1'b1;
      end
   end

   assign sel_valid        = sel ? m1_icb_cmd_valid : m0_icb_cmd_valid;
   assign t_icb_cmd_valid  = sel_valid & ~full;
   assign t_icb_cmd_addr   = sel ? m1_icb_cmd_addr  : m0_icb_cmd_addr;
   assign t_icb_cmd_read   = sel ? m1_icb_cmd_read  : m0_icb_cmd_read;
   assign t_icb_cmd_wdata  = sel ? m1_icb_cmd_wdata : m0_icb_cmd_wdata;
   assign t_icb_cmd_wmask  = sel ? m1_icb_cmd_wmask : m0_icb_cmd_wmask;
   assign m0_icb_cmd_ready = t_icb_cmd_ready & ~full & ~sel;
   assign m1_icb_cmd_ready = t_icb_cmd_ready & ~full &  sel;
   assign cmd_hs           = t_icb_cmd_valid & t_icb_cmd_ready;

   // Hold the grant while the target stalls an offered command, so a
   // command is never switched in the middle of a handshake.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lock    <= 1'b0;
         lock_id <= 1'b0;
      end else if (t_icb_cmd_valid && !t_icb_cmd_ready) begin
         lock    <= 1'b1;
         lock_id <= sel;
      end else if (cmd_hs) begin
         lock    <= 1'b0;
      end
   end

`ifdef E203_ICB_ARB_RR_EN
   // Remember the most recent winner. Reset to m1 so that m0 wins the
   // first contention after reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_gnt <= 1'b1;
      end else if (cmd_hs) begin
         last_gnt <= sel;
      end
   end
`endif

   // Outstanding-ID FIFO status derived from the wrap-extended pointers.
   assign wr_idx = wptr & IDX_MASK;
   assign rd_idx = rptr & IDX_MASK;
   assign empty  = (wptr == rptr);
   assign full   = ((wptr ^ rptr) == FULL_XOR);
   assign busy   = ~empty;

   // Advance the pointers on command issue (push) and response accept (pop).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (cmd_hs) wptr <= wptr + PW'(1);
         if (rsp_hs) rptr <= rptr + PW'(1);
      end
   end

   // Store the granted master ID in the slot the write pointer addresses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         id_mem <= '0;
      end else begin
         for (int i = 0; i < OUTS_DEPTH; i++) begin
            if (cmd_hs && (wr_idx == PW'(i))) id_mem[i] <= sel;
         end
      end
   end

   // Read the ID of the oldest outstanding command.
   always_comb begin
      head = 1'b0;
      for (int i = 0; i < OUTS_DEPTH; i++) begin
         if (rd_idx == PW'(i)) head = id_mem[i];
      end
   end

   // Route responses to the head master. A response that arrives while
   // nothing is outstanding is stray and is never accepted.
   assign m0_icb_rsp_valid = t_icb_rsp_valid & ~empty & ~head;
   assign m1_icb_rsp_valid = t_icb_rsp_valid & ~empty &  head;
   assign t_icb_rsp_ready  = ~empty & (head ? m1_icb_rsp_ready : m0_icb_rsp_ready);
   assign rsp_hs           = t_icb_rsp_valid & t_icb_rsp_ready;
   assign m0_icb_rsp_err   = t_icb_rsp_err;
   assign m1_icb_rsp_err   = t_icb_rsp_err;
   assign m0_icb_rsp_rdata = t_icb_rsp_rdata;
   assign m1_icb_rsp_rdata = t_icb_rsp_rdata;

endmodule

// File: tb/tb_e203_icb_arb2.sv
// Self-checking bench for e203_icb_arb2: directed scenarios followed by
// randomized traffic. All traffic is compared against a transaction-level
// model that keeps an outstanding-ID queue.
module tb_e203_icb_arb2;

   localparam int DEPTH = 2;
`ifdef E203_ICB_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   // clock / reset
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // stimulus
   logic [1:0]  m_valid;
   logic [31:0] m_addr [2];
   logic [1:0]  m_read;
   logic [31:0] m_wdata [2];
   logic [3:0]  m_wmask [2];
   logic [1:0]  m_rsp_ready;
   logic        t_icb_cmd_ready, t_icb_rsp_valid, t_icb_rsp_err;
   logic [31:0] t_icb_rsp_rdata;

   // observed
   logic        m0_icb_cmd_ready, m1_icb_cmd_ready;
   logic        m0_icb_rsp_valid, m1_icb_rsp_valid;
   logic        m0_icb_rsp_err, m1_icb_rsp_err;
   logic [31:0] m0_icb_rsp_rdata, m1_icb_rsp_rdata;
   logic        t_icb_cmd_valid, t_icb_cmd_read, t_icb_rsp_ready, busy;
   logic [31:0] t_icb_cmd_addr, t_icb_cmd_wdata;
   logic [3:0]  t_icb_cmd_wmask;

   e203_icb_arb2 #(.AW(32), .OUTS_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .m0_icb_cmd_valid(m_valid[0]), .m0_icb_cmd_ready(m0_icb_cmd_ready),
      .m0_icb_cmd_addr(m_addr[0]), .m0_icb_cmd_read(m_read[0]),
      .m0_icb_cmd_wdata(m_wdata[0]), .m0_icb_cmd_wmask(m_wmask[0]),
      .m0_icb_rsp_valid(m0_icb_rsp_valid), .m0_icb_rsp_ready(m_rsp_ready[0]),
      .m0_icb_rsp_err(m0_icb_rsp_err), .m0_icb_rsp_rdata(m0_icb_rsp_rdata),
      .m1_icb_cmd_valid(m_valid[1]), .m1_icb_cmd_ready(m1_icb_cmd_ready),
      .m1_icb_cmd_addr(m_addr[1]), .m1_icb_cmd_read(m_read[1]),
      .m1_icb_cmd_wdata(m_wdata[1]), .m1_icb_cmd_wmask(m_wmask[1]),
      .m1_icb_rsp_valid(m1_icb_rsp_valid), .m1_icb_rsp_ready(m_rsp_ready[1]),
      .m1_icb_rsp_err(m1_icb_rsp_err), .m1_icb_rsp_rdata(m1_icb_rsp_rdata),
      .t_icb_cmd_valid(t_icb_cmd_valid), .t_icb_cmd_ready(t_icb_cmd_ready),
      .t_icb_cmd_addr(t_icb_cmd_addr), .t_icb_cmd_read(t_icb_cmd_read),
      .t_icb_cmd_wdata(t_icb_cmd_wdata), .t_icb_cmd_wmask(t_icb_cmd_wmask),
      .t_icb_rsp_valid(t_icb_rsp_valid), .t_icb_rsp_ready(t_icb_rsp_ready),
      .t_icb_rsp_err(t_icb_rsp_err), .t_icb_rsp_rdata(t_icb_rsp_rdata),
      .busy(busy)
   );

   // scoreboard: IDs of commands issued but not yet answered, oldest first
   logic [0:0] exp_q[$];
   logic [0:0] gnt_obs[$];
   bit         mdl_lock, mdl_lock_id, mdl_last;
   bit         cur_sel, cur_tv, cur_rsp_hs;
   bit [1:0]   hs_m;
   int         checks = 0;
   int         failures = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Predict every output from the model state and the current inputs.
   task automatic settle();
      bit full, empty, s, tv, head;
      #1;
      full  = (exp_q.size() == DEPTH);
      empty = (exp_q.size() == 0);
      if (mdl_lock)                    s = mdl_lock_id;
      else if (m_valid == 2'b11)       s = RR ? !mdl_last : 1'b0;
      else                             s = (m_valid == 2'b10);
      tv = m_valid[s] && !full;
      chk("t_cmd_valid", 32'(t_icb_cmd_valid), 32'(tv));
      if (tv) begin
         chk("t_cmd_addr",  t_icb_cmd_addr, m_addr[s]);
         chk("t_cmd_read",  32'(t_icb_cmd_read), 32'(m_read[s]));
         chk("t_cmd_wdata", t_icb_cmd_wdata, m_wdata[s]);
         chk("t_cmd_wmask", 32'(t_icb_cmd_wmask), 32'(m_wmask[s]));
      end
      if (m_valid != 2'b00) begin
         chk("m0_cmd_ready", 32'(m0_icb_cmd_ready), 32'(t_icb_cmd_ready && !full && s == 1'b0));
         chk("m1_cmd_ready", 32'(m1_icb_cmd_ready), 32'(t_icb_cmd_ready && !full && s == 1'b1));
      end
      head = empty ? 1'b0 : exp_q[0];
      chk("m0_rsp_valid", 32'(m0_icb_rsp_valid), 32'(t_icb_rsp_valid && !empty && !head));
      chk("m1_rsp_valid", 32'(m1_icb_rsp_valid), 32'(t_icb_rsp_valid && !empty && head));
      chk("t_rsp_ready",  32'(t_icb_rsp_ready),  32'(!empty && m_rsp_ready[head]));
      chk("m0_rsp_rdata", m0_icb_rsp_rdata, t_icb_rsp_rdata);
      chk("m1_rsp_rdata", m1_icb_rsp_rdata, t_icb_rsp_rdata);
      chk("rsp_err", 32'({m1_icb_rsp_err, m0_icb_rsp_err}), 32'({2{t_icb_rsp_err}}));
      chk("busy", 32'(busy), 32'(!empty));
      cur_sel    = s;
      cur_tv     = tv;
      cur_rsp_hs = t_icb_rsp_valid && !empty && m_rsp_ready[head];
      if (t_icb_cmd_valid && t_icb_cmd_ready) gnt_obs.push_back(m1_icb_cmd_ready);
   endtask

   // Apply this cycle's transfers to the model, then move to the next cycle.
   task automatic advance();
      bit hs;
      hs   = cur_tv && t_icb_cmd_ready;
      hs_m = 2'b00;
      if (cur_rsp_hs) void'(exp_q.pop_front());
      if (hs) begin
         exp_q.push_back(cur_sel);
         mdl_last = cur_sel;
         mdl_lock = 1'b0;
         hs_m[cur_sel] = 1'b1;
      end else if (cur_tv) begin
         mdl_lock    = 1'b1;
         mdl_lock_id = cur_sel;
      end
      @(negedge clk);
   endtask

   task automatic step();
      settle();
      advance();
   endtask

   task automatic idle_inputs();
      m_valid = 2'b00; m_read = 2'b00; m_rsp_ready = 2'b00;
      for (int i = 0; i < 2; i++) begin
         m_addr[i] = '0; m_wdata[i] = '0; m_wmask[i] = '0;
      end
      t_icb_cmd_ready = 1'b0; t_icb_rsp_valid = 1'b0;
      t_icb_rsp_err = 1'b0; t_icb_rsp_rdata = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      exp_q.delete();
      mdl_lock = 1'b0; mdl_lock_id = 1'b0; mdl_last = 1'b1;
      settle();
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic drain();
      m_valid = 2'b00; t_icb_rsp_valid = 1'b1; m_rsp_ready = 2'b11;
      repeat (DEPTH + 1) step();
      t_icb_rsp_valid = 1'b0;
   endtask

   task automatic issue(input int m, input logic [31:0] addr);
      m_valid = 2'b00; m_valid[m] = 1'b1; m_addr[m] = addr; m_read[m] = 1'b1;
      t_icb_cmd_ready = 1'b1;
      step();
      m_valid = 2'b00;
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "simulation did not finish");
   end

   initial begin : main
      logic [0:0] exp_gnt [4];
      idle_inputs();
      @(negedge clk);

      // reset state with all inputs idle
      do_reset();
      settle();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_t_cmd_valid", 32'(t_icb_cmd_valid), 32'd0);
      chk("rst_t_rsp_ready", 32'(t_icb_rsp_ready), 32'd0);
      advance();

      // single master write and its response
      m_valid[0] = 1'b1; m_addr[0] = 32'h8000_0000; m_read[0] = 1'b0;
      m_wdata[0] = 32'hDEAD_BEEF; m_wmask[0] = 4'hF; t_icb_cmd_ready = 1'b1;
      settle();
      chk("single_addr", t_icb_cmd_addr, 32'h8000_0000);
      chk("single_wdata", t_icb_cmd_wdata, 32'hDEAD_BEEF);
      chk("single_wmask", 32'(t_icb_cmd_wmask), 32'hF);
      chk("single_m0_ready", 32'(m0_icb_cmd_ready), 32'd1);
      advance();
      m_valid = 2'b00; t_icb_rsp_valid = 1'b1; t_icb_rsp_err = 1'b0; m_rsp_ready = 2'b11;
      settle();
      chk("single_busy_hi", 32'(busy), 32'd1);
      chk("single_m0_rsp", 32'(m0_icb_rsp_valid), 32'd1);
      chk("single_m1_rsp", 32'(m1_icb_rsp_valid), 32'd0);
      advance();
      t_icb_rsp_valid = 1'b0;
      settle();
      chk("single_busy_lo", 32'(busy), 32'd0);
      advance();

      // contention: both masters valid for four commands
      idle_inputs();
      do_reset();
      m_valid = 2'b11; m_addr[0] = 32'h0000_00A0; m_addr[1] = 32'h0000_00B1;
      t_icb_cmd_ready = 1'b1; t_icb_rsp_valid = 1'b1; m_rsp_ready = 2'b11;
      gnt_obs.delete();
      repeat (4) step();
      exp_gnt = RR ? '{1'b0, 1'b1, 1'b0, 1'b1} : '{1'b0, 1'b0, 1'b0, 1'b0};
      chk("contend_count", gnt_obs.size(), 32'd4);
      for (int i = 0; i < 4 && i < gnt_obs.size(); i++)
         chk($sformatf("contend_gnt%0d", i), 32'(gnt_obs[i]), 32'(exp_gnt[i]));
      drain();

      // lock: m1 stalled by the target, m0 arrives mid-stall
      idle_inputs();
      do_reset();
      m_valid[1] = 1'b1; m_addr[1] = 32'h1111_0000; t_icb_cmd_ready = 1'b0;
      settle(); chk("lock_c1_addr", t_icb_cmd_addr, 32'h1111_0000); advance();
      m_valid[0] = 1'b1; m_addr[0] = 32'h0000_2222;
      settle(); chk("lock_c2_addr", t_icb_cmd_addr, 32'h1111_0000);
      chk("lock_c2_m0_ready", 32'(m0_icb_cmd_ready), 32'd0); advance();
      settle(); chk("lock_c3_addr", t_icb_cmd_addr, 32'h1111_0000); advance();
      t_icb_cmd_ready = 1'b1;
      settle(); chk("lock_m1_done", 32'(m1_icb_cmd_ready), 32'd1);
      chk("lock_m0_wait", 32'(m0_icb_cmd_ready), 32'd0); advance();
      m_valid[1] = 1'b0;
      settle(); chk("lock_m0_addr", t_icb_cmd_addr, 32'h0000_2222);
      chk("lock_m0_ready", 32'(m0_icb_cmd_ready), 32'd1); advance();
      drain();

      // full: two reads outstanding block a third command
      idle_inputs();
      do_reset();
      issue(0, 32'h10);
      issue(1, 32'h20);
      m_valid[0] = 1'b1; m_addr[0] = 32'h30;
      settle(); chk("full_m0_ready", 32'(m0_icb_cmd_ready), 32'd0);
      chk("full_t_valid", 32'(t_icb_cmd_valid), 32'd0); advance();
      t_icb_rsp_valid = 1'b1; t_icb_rsp_rdata = 32'h1234_5678; m_rsp_ready = 2'b11;
      settle(); chk("full_rsp_m0", 32'(m0_icb_rsp_valid), 32'd1);
      chk("full_rsp_rdata", m0_icb_rsp_rdata, 32'h1234_5678);
      chk("full_pop_blocks", 32'(m0_icb_cmd_ready), 32'd0); advance();
      t_icb_rsp_valid = 1'b0;
      settle(); chk("full_third_ok", 32'(m0_icb_cmd_ready), 32'd1);
      chk("full_third_addr", t_icb_cmd_addr, 32'h30); advance();
      drain();

      // head master stalls its response
      idle_inputs();
      do_reset();
      issue(1, 32'h40);
      issue(0, 32'h50);
      t_icb_cmd_ready = 1'b0; t_icb_rsp_valid = 1'b1; m_rsp_ready = 2'b01;
      for (int i = 0; i < 2; i++) begin
         settle(); chk("ooo_t_rsp_ready", 32'(t_icb_rsp_ready), 32'd0);
         chk("ooo_m0_rsp", 32'(m0_icb_rsp_valid), 32'd0);
         chk("ooo_m1_rsp", 32'(m1_icb_rsp_valid), 32'd1); advance();
      end
      m_rsp_ready = 2'b11;
      settle(); chk("ooo_m1_accept", 32'(t_icb_rsp_ready), 32'd1); advance();
      settle(); chk("ooo_m0_next", 32'(m0_icb_rsp_valid), 32'd1); advance();
      t_icb_rsp_valid = 1'b0;
      step();

      // reset with two outstanding, then a stray response
      idle_inputs();
      do_reset();
      issue(0, 32'h60);
      issue(1, 32'h70);
      idle_inputs();
      do_reset();
      t_icb_rsp_valid = 1'b1; m_rsp_ready = 2'b11;
      settle(); chk("stray_t_rsp_ready", 32'(t_icb_rsp_ready), 32'd0);
      chk("stray_rsp_valid", 32'({m1_icb_rsp_valid, m0_icb_rsp_valid}), 32'd0);
      chk("stray_busy", 32'(busy), 32'd0); advance();
      t_icb_rsp_valid = 1'b0;

      // randomized traffic with ICB-compliant masters
      idle_inputs();
      do_reset();
      for (int c = 0; c < 1500; c++) begin
         for (int i = 0; i < 2; i++) begin
            if (!m_valid[i] && $urandom_range(0, 2) == 0) begin
               m_valid[i] = 1'b1; m_addr[i] = $urandom; m_read[i] = 1'($urandom_range(0, 1));
               m_wdata[i] = $urandom; m_wmask[i] = 4'($urandom_range(0, 15));
            end
            m_rsp_ready[i] = ($urandom_range(0, 3) != 0);
         end
         t_icb_cmd_ready = ($urandom_range(0, 3) != 0);
         t_icb_rsp_valid = 1'($urandom_range(0, 1));
         t_icb_rsp_err   = 1'($urandom_range(0, 1));
         t_icb_rsp_rdata = $urandom;
         if ($urandom_range(0, 299) == 0) begin
            do_reset();
         end else begin
            step();
            for (int i = 0; i < 2; i++) if (hs_m[i]) m_valid[i] = 1'b0;
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
